apb_master_bridge: RTL
======================

Name: apb_master_bridge

Overview:
- Converts a simple valid/ready command stream into AMBA 3 APB (rev B) master transfers, and returns one response per command.
- Sits directly upstream of the APB rev B interface and drives its master modport: paddr, pselx, penable, pwrite, pwdata out; pready, prdata, pslverr in.
- One transfer in flight at a time; no command buffering.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and paddr.
- DATA_WIDTH, 32, width of write/read data paths.
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase wait cycles; used only when APB_MASTER_TIMEOUT_EN is defined; must be >= 1.

Ports:
- pclk  input  1  APB clock; all logic is on its rising edge.
- presetn  input  1  reset; one clock; reset is asynchronous and active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  bridge accepts command this cycle.
- cmd_addr  input  ADDR_WIDTH  transfer address.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_wdata  input  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes the response.
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes.
- rsp_slverr  output  1  error reported by the slave (or by timeout).
- paddr  output  ADDR_WIDTH  APB address.
- pselx  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- pwdata  output  DATA_WIDTH  APB write data.
- pready  input  1  slave ready.
- prdata  input  DATA_WIDTH  slave read data.
- pslverr  input  1  slave error.

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, RESP.
- Reset values: state IDLE; all outputs 0 (cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, paddr, pselx, penable, pwrite, pwdata).
- Reset is asynchronous and takes effect mid-transfer. Any in-flight transfer or pending response is dropped, and pselx/penable fall immediately.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, register cmd_addr, cmd_write and cmd_wdata into paddr, pwrite and pwdata, then go to SETUP.
- SETUP (exactly 1 cycle): pselx = 1, penable = 0; then go to ACCESS.
- ACCESS:
  - pselx = 1, penable = 1.
  - Each cycle pready = 0 inserts a wait state.
  - On pready = 1: capture pslverr into rsp_slverr. Capture prdata into rsp_rdata if pwrite = 0; otherwise load 0. Then go to RESP.
- RESP:
  - pselx = 0, penable = 0, rsp_valid = 1.
  - rsp_rdata and rsp_slverr are held stable until rsp_valid & rsp_ready; then go to IDLE.
- cmd_ready is 0 in SETUP, ACCESS and RESP.
- paddr, pwrite and pwdata change only on command acceptance. They hold their last values in IDLE.
- Latency:
  - Command accepted in cycle N gives SETUP at N+1 and ACCESS at N+2.
  - With zero wait states, rsp_valid is high at N+3.
  - Each wait state adds 1 cycle.
  - Minimum spacing between accepted commands is 4 cycles.
- pslverr is only meaningful when pready = 1 in ACCESS; it is ignored at all other times.
- rsp_ready held high in RESP gives a 1-cycle response. Backpressure of any length is legal.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ACCESS and increments on each pready = 0 cycle.
  - When the count reaches TIMEOUT_CYCLES with pready still 0, the bridge aborts: go to RESP with rsp_slverr = 1 and rsp_rdata = 0. pselx/penable drop in the following cycle.
  - pready = 1 in the same cycle that the count reaches the limit counts as normal completion (slave wins).
- Not defined: no counter logic; ACCESS waits indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package apb_pkg:
  - enum apb_state_t {IDLE, SETUP, ACCESS, RESP}.
  - constants APB_DEFAULT_ADDR_WIDTH = 32 and APB_DEFAULT_DATA_WIDTH = 32.
- No sub-module. The FSM and the optional counter fit in a single module.

Test Plan:
- Write addr 0x0000_0010, wdata 0xDEAD_BEEF, pready tied 1 -> SETUP at N+1, ACCESS at N+2, pwdata = 0xDEADBEEF; rsp_valid at N+3 with rsp_slverr = 0, rsp_rdata = 0.
- Read addr 0x0000_0020, pready low for 3 ACCESS cycles, prdata = 0x1234_5678 on completion -> penable high for 4 cycles; rsp_rdata = 0x12345678; rsp_valid at N+6.
- Read with pslverr = 1 at completion -> rsp_slverr = 1; the next command completes with rsp_slverr = 0.
- rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stable, cmd_ready = 0, pselx = 0; the command presented after rsp_ready is accepted the cycle after.
- presetn pulsed low during ACCESS -> pselx, penable and rsp_valid go to 0 asynchronously; after release, cmd_ready = 1 and the next read completes normally.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 4, pready held 0 -> RESP after 4 wait cycles with rsp_slverr = 1, rsp_rdata = 0. A second run with pready = 1 exactly on the 4th wait cycle -> normal completion, rsp_slverr = 0.

Source files
------------

// File: rtl/apb_pkg.sv
// ----------------------------------------------------------------------------
// Module : apb_pkg
// Shared state encoding and default widths for the APB master bridge.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package apb_pkg;

    localparam int APB_DEFAULT_ADDR_WIDTH = 32;
    localparam int APB_DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

endpackage

`default_nettype wire

// File: rtl/apb_master_bridge.sv
// ----------------------------------------------------------------------------
// Module : apb_master_bridge
// Valid/ready command stream to AMBA 3 APB master, one response per command.
// Optional ACCESS-phase timeout enabled by defining APB_MASTER_TIMEOUT_EN.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pselx,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pslverr
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYCLES must be >= 1");
    end

    apb_state_t            r_state;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_slverr;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int                 c_CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [c_CNT_W-1:0]            r_wait_cnt;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state      <= IDLE;
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_slverr <= 1'b0;
            r_paddr      <= '0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_pwdata     <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            r_wait_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_paddr     <= cmd_addr;
                        r_pwrite    <= cmd_write;
                        r_pwdata    <= cmd_wdata;
                        r_cmd_ready <= 1'b0;
                        r_psel      <= 1'b1;
                        r_state     <= SETUP;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    r_penable  <= 1'b1;
                    r_state    <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                ACCESS: begin
                    if (pready) begin
                        r_psel       <= 1'b0;
                        r_penable    <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_slverr <= pslverr;
                        r_rsp_rdata  <= r_pwrite ? '0 : prdata;
                        r_state      <= RESP;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    // This wait cycle is the last one allowed: abort with an error.
                    else if (r_wait_cnt == c_TO_LAST) begin
                        r_psel       <= 1'b0;
                        r_penable    <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_slverr <= 1'b1;
                        r_rsp_rdata  <= '0;
                        r_state      <= RESP;
                    end else begin
                        r_wait_cnt   <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_slverr = r_rsp_slverr;
    assign paddr      = r_paddr;
    assign pselx      = r_psel;
    assign penable    = r_penable;
    assign pwrite     = r_pwrite;
    assign pwdata     = r_pwdata;

endmodule

`default_nettype wire
